// File: rtl/prbs7_xnor_checker.sv
// Receive-side checker for the XNOR-feedback PRBS7 stream (x^7+x^6+1).
// Seeds its LFSR from the line, declares lock, then free-runs and counts bit errors.
module prbs7_xnor_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_WIN = 64,
    parameter int LOSS_THR = 8,
    parameter int ERR_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             din_valid_i,
    input  logic             din_i,
    input  logic             clear_err_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(LOSS_WIN);
    localparam int WERR_W  = $clog2(LOSS_THR + 1);

    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(LOSS_WIN - 1);
    localparam logic [WERR_W-1:0]  THR_V     = WERR_W'(LOSS_THR);

    typedef enum logic {SEARCH, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [6:0]         s_q, s_d;
    logic [2:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_bits_q, win_bits_d;
    logic [WERR_W-1:0]  win_errs_q, win_errs_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               err_pulse_q, err_pulse_d;

    logic               pred;
    logic               err;
    logic [MATCH_W-1:0] match_inc;
    logic [WERR_W-1:0]  win_errs_inc;

    assign pred         = ~(s_q[6] ^ s_q[5]);
    assign err          = din_i ^ pred;
    assign match_inc    = match_q + 1'b1;
    assign win_errs_inc = win_errs_q + WERR_W'(err);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;

        if (din_valid_i) begin
            case (state_q)
                SEARCH: begin
                    s_d = {s_q[5:0], din_i};
                    if (fill_q != 3'd7) begin
                        fill_d = fill_q + 3'd1;
                    end else if (!err && (s_q != 7'h7F)) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_LAST) begin
                            state_d    = LOCKED;
                            win_bits_d = '0;
                            win_errs_d = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on our own prediction so corrupted line bits never reseed us.
                    s_d         = {s_q[5:0], pred};
                    err_pulse_d = err;
                    if (err && (err_count_q != {ERR_W{1'b1}})) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    if (win_errs_inc == THR_V) begin
                        state_d    = SEARCH;
                        fill_d     = '0;
                        match_d    = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else if (win_bits_q == WIN_LAST) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = win_bits_q + 1'b1;
                        win_errs_d = win_errs_inc;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clear_err_i) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEARCH;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Directed/randomised bench for prbs7_xnor_checker: a default instance and an ERR_W=4
// instance share stimulus and are compared every cycle against a bit-history model.
module tb_prbs7_xnor_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic        lockedA, pulseA, lockedB, pulseB;
    logic [15:0] cntA;
    logic [3:0]  cntB;

    int errors = 0;
    int checks = 0;

    prbs7_xnor_checker dutA (
        .clk_i(clk), .rst_ni(rst_n), .din_valid_i(vld), .din_i(din), .clear_err_i(clr),
        .locked_o(lockedA), .err_pulse_o(pulseA), .err_count_o(cntA)
    );

    prbs7_xnor_checker #(.ERR_W(4)) dutB (
        .clk_i(clk), .rst_ni(rst_n), .din_valid_i(vld), .din_i(din), .clear_err_i(clr),
        .locked_o(lockedB), .err_pulse_o(pulseB), .err_count_o(cntB)
    );

    always #5 clk = ~clk;

    // Reference: hist holds the last seven bits fed to the predictor, oldest first.
    bit hist[$];
    bit mLocked, mPulse;
    int mFill, mMatch, mWinBits, mWinErrs, mCntA, mCntB;
    bit [6:0] gState;

    task automatic modelReset();
        hist = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        mLocked = 0; mPulse = 0; mFill = 0; mMatch = 0;
        mWinBits = 0; mWinErrs = 0; mCntA = 0; mCntB = 0;
    endtask

    task automatic modelStep(input bit v, input bit d, input bit c);
        bit p, e, allOnes;
        mPulse = 0;
        if (v) begin
            p = !(hist[0] ^ hist[1]);
            allOnes = 1;
            foreach (hist[k]) if (!hist[k]) allOnes = 0;
            if (!mLocked) begin
                if (mFill < 7) mFill++;
                else if (d == p && !allOnes) mMatch++;
                else mMatch = 0;
                hist.push_back(d);
                void'(hist.pop_front());
                if (mMatch == 16) begin
                    mLocked = 1; mWinBits = 0; mWinErrs = 0;
                end
            end else begin
                e = (d != p);
                hist.push_back(p);
                void'(hist.pop_front());
                mPulse = e;
                if (e) begin
                    if (mCntA < 65535) mCntA++;
                    if (mCntB < 15) mCntB++;
                end
                if (mWinErrs + int'(e) >= 8) begin
                    mLocked = 0; mFill = 0; mMatch = 0; mWinBits = 0; mWinErrs = 0;
                end else if (mWinBits == 63) begin
                    mWinBits = 0; mWinErrs = 0;
                end else begin
                    mWinBits++; mWinErrs += int'(e);
                end
            end
        end
        if (c) begin
            mCntA = 0; mCntB = 0;
        end
    endtask

    task automatic nextGen(output bit b);
        b = !(gState[6] ^ gState[5]);
        gState = {gState[5:0], b};
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".lockedA"}, 32'(lockedA), 32'(mLocked));
        chk({tag, ".lockedB"}, 32'(lockedB), 32'(mLocked));
        chk({tag, ".pulseA"},  32'(pulseA),  32'(mPulse));
        chk({tag, ".pulseB"},  32'(pulseB),  32'(mPulse));
        chk({tag, ".cntA"},    32'(cntA),    32'(mCntA));
        chk({tag, ".cntB"},    32'(cntB),    32'(mCntB));
    endtask

    task automatic applyStimulus(input string tag, input bit v, input bit d, input bit c);
        vld = v; din = d; clr = c;
        @(posedge clk);
        modelStep(v, d, c);
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        rst_n = 0; vld = 0; din = 0; clr = 0;
        #2;
        modelReset();
        checkOutput("reset");
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        bit b;
        int lockAt, lossAt;
        bit sawLock;

        $display("[TB] start");
        // 1: clean stream from seed 0, lock at bit 23, no errors over 1000 bits
        doReset();
        gState = 7'h00;
        lockAt = -1;
        for (int i = 1; i <= 1000; i++) begin
            nextGen(b);
            applyStimulus("clean", 1, b, 0);
            if (lockAt < 0 && lockedA === 1'b1) lockAt = i;
        end
        chk("lockBit", 32'(lockAt), 32'd23);
        chk("cleanCnt", 32'(cntA), 32'd0);

        // 2: single flipped bit while locked
        for (int i = 1; i <= 150; i++) begin
            nextGen(b);
            applyStimulus("single", 1, (i == 100) ? !b : b, 0);
            if (i == 100) chk("singlePulse", 32'(pulseA), 32'd1);
            if (i == 101) chk("singlePulseEnd", 32'(pulseA), 32'd0);
        end
        chk("singleCnt", 32'(cntA), 32'd1);
        chk("singleLocked", 32'(lockedA), 32'd1);

        // 3: eight errors inside one window -> loss, then relock on clean data
        doReset();
        gState = 7'($urandom_range(0, 126));
        for (int i = 1; i <= 23; i++) begin
            nextGen(b);
            applyStimulus("relockPre", 1, b, 0);
        end
        chk("burstLockedPre", 32'(lockedA), 32'd1);
        for (int i = 1; i <= 24; i++) begin
            nextGen(b);
            applyStimulus("burst", 1, (i % 3 == 0) ? !b : b, 0);
        end
        chk("burstLoss", 32'(lockedA), 32'd0);
        chk("burstCnt", 32'(cntA), 32'd8);
        lossAt = -1;
        for (int i = 1; i <= 40; i++) begin
            nextGen(b);
            applyStimulus("relock", 1, b, 0);
            if (lossAt < 0 && lockedA === 1'b1) lossAt = i;
        end
        chk("relockBit", 32'(lossAt), 32'd23);
        chk("relockCnt", 32'(cntA), 32'd8);

        // 4: stuck-at-one line must never lock
        doReset();
        sawLock = 0;
        for (int i = 1; i <= 200; i++) begin
            applyStimulus("stuck1", 1, 1, 0);
            if (lockedA !== 1'b0) sawLock = 1;
        end
        chk("stuckNoLock", 32'(sawLock), 32'd0);

        // 5: one error per window, saturation of the narrow counter, clear beats error
        doReset();
        gState = 7'($urandom_range(0, 126));
        for (int i = 1; i <= 23; i++) begin
            nextGen(b);
            applyStimulus("satLock", 1, b, 0);
        end
        for (int w = 0; w < 20; w++) begin
            for (int k = 1; k <= 64; k++) begin
                nextGen(b);
                applyStimulus("sat", 1, (k == 10) ? !b : b, 0);
            end
        end
        chk("satCntB", 32'(cntB), 32'd15);
        chk("satCntA", 32'(cntA), 32'd20);
        chk("satLocked", 32'(lockedA), 32'd1);
        nextGen(b);
        applyStimulus("clrErr", 1, !b, 1);
        chk("clrCntB", 32'(cntB), 32'd0);
        chk("clrCntA", 32'(cntA), 32'd0);
        chk("clrPulse", 32'(pulseB), 32'd1);

        // 6: valid every other cycle, then asynchronous reset while locked
        doReset();
        gState = 7'($urandom_range(0, 126));
        lockAt = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc % 2 == 1) begin
                nextGen(b);
                applyStimulus("gappy", 1, b, 0);
            end else begin
                applyStimulus("gappy", 0, 1'($urandom), 1'($urandom_range(0, 9) == 0));
            end
            if (lockAt < 0 && lockedA === 1'b1) lockAt = cyc;
        end
        chk("gappyLockCyc", 32'(lockAt), 32'd45);
        #2 rst_n = 0;
        #1;
        modelReset();
        chk("asyncLocked", 32'(lockedA), 32'd0);
        chk("asyncCnt", 32'(cntA), 32'd0);
        checkOutput("asyncReset");
        @(posedge clk);
        #1 rst_n = 1;
        applyStimulus("postReset", 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
